// File: rtl/comp_acc_if.sv
// Val-rdy bundle between the complex multiplier, the accumulator and its consumer.
// Term stream {xr,yr} in, widened complex sum {xs,ys} plus term count out.
interface comp_acc_if #(
   parameter int DWIDTH = 8,
   parameter int GWIDTH = 2
);
   localparam int IWIDTH = 2 * (DWIDTH + 1);
   localparam int OWIDTH = IWIDTH + GWIDTH;

   logic                  in_val;
   logic                  in_rdy;
   logic [2*IWIDTH-1:0]   in_data;
   logic                  in_last;
   logic                  acc_val;
   logic                  acc_rdy;
   logic [2*OWIDTH-1:0]   acc_data;
   logic [GWIDTH:0]       acc_cnt;

   modport master (
      output in_val, in_data, in_last, acc_rdy,
      input  in_rdy, acc_val, acc_data, acc_cnt
   );

   modport slave (
      input  in_val, in_data, in_last, acc_rdy,
      output in_rdy, acc_val, acc_data, acc_cnt
   );
endinterface

// File: rtl/comp_acc.sv
// Complex accumulator: sums up to NACC complex terms per group on both parts,
// then holds the widened sum until the consumer takes it.
module comp_acc #(
   parameter int DWIDTH = 8,
   parameter int NACC   = 4,
   parameter int GWIDTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sw_rst,
   comp_acc_if.slave  bus
);
   localparam int IWIDTH = 2 * (DWIDTH + 1);
   localparam int OWIDTH = IWIDTH + GWIDTH;
   localparam int CW     = GWIDTH + 1;

   typedef enum logic {ST_ACC, ST_OUT} state_t;

   state_t              state_q, state_d;
   logic [OWIDTH-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic [OWIDTH-1:0]   res_x_q, res_x_d, res_y_q, res_y_d;
   logic [CW-1:0]       cnt_q, cnt_d, res_cnt_q, res_cnt_d;
   logic                in_rdy_q, in_rdy_d, acc_val_q, acc_val_d;

   logic [OWIDTH-1:0]   term_x, term_y, next_x, next_y;
   logic [CW-1:0]       cnt_inc;
   logic                xfer, close;

   always_comb begin
      term_x  = {{GWIDTH{bus.in_data[2*IWIDTH-1]}}, bus.in_data[2*IWIDTH-1:IWIDTH]};
      term_y  = {{GWIDTH{bus.in_data[IWIDTH-1]}},   bus.in_data[IWIDTH-1:0]};
      next_x  = sum_x_q + term_x;
      next_y  = sum_y_q + term_y;
      cnt_inc = cnt_q + CW'(1);
      xfer    = bus.in_val & in_rdy_q;
      // in_last on the NACC-th term folds into the same single close
      close   = xfer & (bus.in_last | (cnt_inc == CW'(NACC)));

      state_d   = state_q;
      sum_x_d   = sum_x_q;
      sum_y_d   = sum_y_q;
      cnt_d     = cnt_q;
      res_x_d   = res_x_q;
      res_y_d   = res_y_q;
      res_cnt_d = res_cnt_q;
      in_rdy_d  = in_rdy_q;
      acc_val_d = acc_val_q;

      if (state_q == ST_ACC) begin
         if (close) begin
            res_x_d   = next_x;
            res_y_d   = next_y;
            res_cnt_d = cnt_inc;
            sum_x_d   = '0;
            sum_y_d   = '0;
            cnt_d     = '0;
            acc_val_d = 1'b1;
            in_rdy_d  = 1'b0;
            state_d   = ST_OUT;
         end else if (xfer) begin
            sum_x_d = next_x;
            sum_y_d = next_y;
            cnt_d   = cnt_inc;
         end
      end else begin
         if (bus.acc_rdy) begin
            acc_val_d = 1'b0;
            in_rdy_d  = 1'b1;
            state_d   = ST_ACC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || sw_rst) begin
         state_q   <= ST_ACC;
         sum_x_q   <= '0;
         sum_y_q   <= '0;
         cnt_q     <= '0;
         res_x_q   <= '0;
         res_y_q   <= '0;
         res_cnt_q <= '0;
         in_rdy_q  <= 1'b1;
         acc_val_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sum_x_q   <= sum_x_d;
         sum_y_q   <= sum_y_d;
         cnt_q     <= cnt_d;
         res_x_q   <= res_x_d;
         res_y_q   <= res_y_d;
         res_cnt_q <= res_cnt_d;
         in_rdy_q  <= in_rdy_d;
         acc_val_q <= acc_val_d;
      end
   end

   assign bus.in_rdy   = in_rdy_q;
   assign bus.acc_val  = acc_val_q;
   assign bus.acc_data = {res_x_q, res_y_q};
   assign bus.acc_cnt  = res_cnt_q;
endmodule

// File: tb/tb_comp_acc.sv
// Bench for comp_acc: integer group-sum model checked every cycle, plus
// directed groups with hand-computed sums.
module tb_comp_acc;
   localparam int DW   = 8;
   localparam int NACC = 4;
   localparam int GW   = 2;
   localparam int IW   = 2 * (DW + 1);
   localparam int OW   = IW + GW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sw_rst = 1'b0;
   always #5 clk = ~clk;

   comp_acc_if #(.DWIDTH(DW), .GWIDTH(GW)) bus ();

   comp_acc #(.DWIDTH(DW), .NACC(NACC), .GWIDTH(GW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_rst (sw_rst),
      .bus    (bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 0;

   // Model: result register contents, open group sums, output-pending flag
   bit m_out;
   int m_sx, m_sy, m_n, m_rx, m_ry, m_rc, m_terms;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   function automatic int dut_xs();
      return int'($signed(bus.acc_data[2*OW-1:OW]));
   endfunction

   function automatic int dut_ys();
      return int'($signed(bus.acc_data[OW-1:0]));
   endfunction

   always @(posedge clk) begin : model
      int xr, yr;
      xr = int'($signed(bus.in_data[2*IW-1:IW]));
      yr = int'($signed(bus.in_data[IW-1:0]));
      if (!rst_n || sw_rst) begin
         m_out = 0; m_sx = 0; m_sy = 0; m_n = 0; m_rx = 0; m_ry = 0; m_rc = 0;
      end else if (m_out) begin
         if (bus.acc_rdy) m_out = 0;
      end else if (bus.in_val) begin
         m_sx += xr; m_sy += yr; m_n++; m_terms++;
         if (bus.in_last || m_n == NACC) begin
            m_rx = m_sx; m_ry = m_sy; m_rc = m_n;
            m_sx = 0; m_sy = 0; m_n = 0;
            m_out = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_in_rdy",  int'(bus.in_rdy),  int'(!m_out));
         chk("cyc_acc_val", int'(bus.acc_val), int'(m_out));
         chk("cyc_xs",      dut_xs(),          m_rx);
         chk("cyc_ys",      dut_ys(),          m_ry);
         chk("cyc_cnt",     int'(bus.acc_cnt), m_rc);
      end
   end

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic send(input int x, input int y, input bit last);
      bus.in_val  = 1'b1;
      bus.in_data = {IW'(x), IW'(y)};
      bus.in_last = last;
      for (int t = 0; t < 100; t++) begin
         if (bus.in_rdy) begin
            @(negedge clk);
            bus.in_val  = 1'b0;
            bus.in_last = 1'b0;
            return;
         end
         @(negedge clk);
      end
      chk("send_timeout", 0, 1);
      bus.in_val  = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic chk_res(input string name, input int x, input int y, input int c);
      chk({name, "_val"}, int'(bus.acc_val), 1);
      chk({name, "_xs"},  dut_xs(),          x);
      chk({name, "_ys"},  dut_ys(),          y);
      chk({name, "_cnt"}, int'(bus.acc_cnt), c);
   endtask

   initial begin
      int start;
      bus.in_val  = 1'b0;
      bus.in_data = '0;
      bus.in_last = 1'b0;
      bus.acc_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1;
      chk("rst_in_rdy",  int'(bus.in_rdy),  1);
      chk("rst_acc_val", int'(bus.acc_val), 0);
      chk("rst_data",    int'(bus.acc_data != '0), 0);
      chk("rst_cnt",     int'(bus.acc_cnt), 0);
      rst_n = 1'b1;

      // Full group back to back
      bus.acc_rdy = 1'b1;
      repeat (4) send(100, -50, 0);
      chk_res("full", 400, -200, 4);
      chk("full_in_rdy_low", int'(bus.in_rdy), 0);
      @(negedge clk);
      chk("full_in_rdy_back", int'(bus.in_rdy), 1);
      chk("full_val_drop", int'(bus.acc_val), 0);

      // Early close, then a fresh single-term group
      send(7, 3, 0);
      send(-2, 5, 1);
      chk_res("early", 5, 8, 2);
      send(1, 1, 1);
      chk_res("single", 1, 1, 1);
      @(negedge clk);

      // Backpressure with new data pending
      bus.acc_rdy = 1'b0;
      repeat (4) send(10, -10, 0);
      bus.in_val  = 1'b1;
      bus.in_data = {IW'(99), IW'(99)};
      repeat (10) begin
         @(negedge clk);
         chk_res("bp", 40, -40, 4);
         chk("bp_in_rdy", int'(bus.in_rdy), 0);
      end
      bus.acc_rdy = 1'b1;
      @(negedge clk);
      chk("bp_release_val", int'(bus.acc_val), 0);
      chk("bp_release_rdy", int'(bus.in_rdy), 1);
      bus.in_val = 1'b0;

      // Extreme products
      repeat (4) send(-16384, 32768, 0);
      chk_res("extreme", -65536, 131072, 4);
      @(negedge clk);

      // sw_rst mid-group
      send(5, 5, 0);
      send(5, 5, 0);
      sw_rst = 1'b1;
      @(negedge clk);
      sw_rst = 1'b0;
      chk("swrst_in_rdy",  int'(bus.in_rdy),  1);
      chk("swrst_acc_val", int'(bus.acc_val), 0);
      chk("swrst_xs",      dut_xs(),          0);
      bus.acc_rdy = 1'b0;
      repeat (4) send(1, 0, 0);
      chk_res("after_swrst", 4, 0, 4);

      // rst_n while in OUT
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("hwrst_acc_val", int'(bus.acc_val), 0);
      chk("hwrst_data",    int'(bus.acc_data != '0), 0);
      chk("hwrst_cnt",     int'(bus.acc_cnt), 0);
      chk("hwrst_in_rdy",  int'(bus.in_rdy),  1);

      // Random traffic
      start = m_terms;
      for (int cyc = 0; cyc < 20000 && (m_terms - start) < 1000; cyc++) begin
         bus.in_val  = ($urandom_range(0, 3) != 0);
         bus.in_data = {IW'(int'($urandom_range(0, 2**IW - 1)) - 2**(IW-1)),
                        IW'(int'($urandom_range(0, 2**IW - 1)) - 2**(IW-1))};
         bus.in_last = ($urandom_range(0, 4) == 0);
         bus.acc_rdy = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end
      bus.in_val  = 1'b0;
      bus.in_last = 1'b0;
      bus.acc_rdy = 1'b1;
      chk("random_terms_done", int'((m_terms - start) >= 1000), 1);
      repeat (3) @(negedge clk);

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
